// File: rtl/gpu_isa_pkg.sv
// rtl/gpu_isa_pkg.sv - shared ISA constants, field positions, encoder states and encode helpers
package gpu_isa_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BRNZP = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_LDR   = 4'h7;
  localparam logic [3:0] OP_STR   = 4'h8;
  localparam logic [3:0] OP_CONST = 4'h9;
  localparam logic [3:0] OP_RET   = 4'hF;

  localparam int OPCODE_LSB = 12;
  localparam int RD_LSB     = 8;
  localparam int RS_LSB     = 4;
  localparam int RT_LSB     = 0;
  localparam int NZP_LSB    = 9;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } enc_state_t;

  // 1010..1110 are reserved; everything else is a real instruction
  function automatic logic opcode_legal(input logic [3:0] op);
    return (op <= OP_CONST) || (op == OP_RET);
  endfunction

  function automatic logic [15:0] encode_word(
    input logic [3:0] op,
    input logic [3:0] rd,
    input logic [3:0] rs,
    input logic [3:0] rt,
    input logic [2:0] nzp,
    input logic [7:0] imm
  );
    logic [15:0] w;
    w = '0;
    w[OPCODE_LSB +: 4] = op;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        w[RD_LSB +: 4] = rd;
        w[RS_LSB +: 4] = rs;
        w[RT_LSB +: 4] = rt;
      end
      OP_CMP, OP_STR: begin
        w[RS_LSB +: 4] = rs;
        w[RT_LSB +: 4] = rt;
      end
      OP_LDR: begin
        w[RD_LSB +: 4] = rd;
        w[RS_LSB +: 4] = rs;
      end
      OP_BRNZP: begin
        w[NZP_LSB +: 3] = nzp;
        w[IMM_LSB +: 8] = imm;
      end
      OP_CONST: begin
        w[RD_LSB +: 4]  = rd;
        w[IMM_LSB +: 8] = imm;
      end
      OP_NOP, OP_RET: ;
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - instruction-field input and program-memory write handshakes
interface instruction_encoder_if #(
  parameter int ADDR_BITS = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_opcode;
  logic [3:0]           in_rd;
  logic [3:0]           in_rs;
  logic [3:0]           in_rt;
  logic [2:0]           in_nzp;
  logic [7:0]           in_imm;

  logic                 mem_write_valid;
  logic                 mem_write_ready;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [15:0]          mem_write_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_imm,
    input  in_ready,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_imm,
    output in_ready,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO holding encoded words awaiting program-memory writes
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_BITS:0] wr_ptr;
  logic [PTR_BITS:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // extra pointer bit distinguishes full from empty when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                    (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PTR_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_BITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - encodes instruction fields into 16-bit words and streams them to program memory
module instruction_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_address,
  instruction_encoder_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_opcode,
  output logic                 err_overflow
);

  import gpu_isa_pkg::*;

  localparam logic [ADDR_BITS:0] ADDR_SPACE = {1'b1, {ADDR_BITS{1'b0}}};

  enc_state_t           state;
  enc_state_t           state_next;
  logic [ADDR_BITS-1:0] head_address;
  logic [ADDR_BITS:0]   word_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [15:0]          fifo_data;
  logic                 start_ok;
  logic                 accept;
  logic                 legal;
  logic                 room;
  logic                 push;
  logic                 pop;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign legal    = opcode_legal(bus.in_opcode);
  assign room     = (word_count < ADDR_SPACE);
  assign accept   = bus.in_valid && bus.in_ready;
  assign push     = accept && legal && room;
  assign pop      = bus.mem_write_valid && bus.mem_write_ready;

  assign bus.in_ready          = (state == S_ACTIVE) && !fifo_full;
  assign bus.mem_write_valid   = !fifo_empty;
  assign bus.mem_write_address = bus.mem_write_valid ? head_address : '0;
  assign bus.mem_write_data    = bus.mem_write_valid ? fifo_data : '0;
  assign busy                  = (state == S_ACTIVE) || (state == S_DRAIN);
  assign done                  = (state == S_DONE);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (encode_word(bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt,
                            bus.in_nzp, bus.in_imm)),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // a RET ends the session even when it was dropped for lack of address space
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_ACTIVE;
      S_ACTIVE:       if (accept && (bus.in_opcode == OP_RET)) state_next = S_DRAIN;
      S_DRAIN:        if (fifo_empty) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // the head address tracks writes, so dropped opcodes never leave a hole
  always_ff @(posedge clk) begin
    if (reset) begin
      head_address <= '0;
      word_count   <= '0;
      err_opcode   <= 1'b0;
      err_overflow <= 1'b0;
    end else if (start_ok) begin
      head_address <= base_address;
      word_count   <= '0;
      err_opcode   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (pop)                      head_address <= head_address + ADDR_BITS'(1);
      if (push)                     word_count   <= word_count + (ADDR_BITS+1)'(1);
      if (accept && !legal)         err_opcode   <= 1'b1;
      if (accept && legal && !room) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - bench driving an 8-bit and a 2-bit address encoder against a reference model
module tb_instruction_encoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_address = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [2:0] in_nzp = '0;
  logic [7:0] in_imm = '0;
  logic       mem_ready = 1'b0;

  logic        o_valid[2], o_ready[2], o_busy[2], o_done[2], o_eop[2], o_eov[2];
  logic [7:0]  o_addr[2];
  logic [15:0] o_data[2];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  instruction_encoder_if #(.ADDR_BITS(8)) bus0 ();
  instruction_encoder_if #(.ADDR_BITS(2)) bus1 ();

  assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
  assign bus0.in_opcode = in_opcode; assign bus1.in_opcode = in_opcode;
  assign bus0.in_rd = in_rd;         assign bus1.in_rd = in_rd;
  assign bus0.in_rs = in_rs;         assign bus1.in_rs = in_rs;
  assign bus0.in_rt = in_rt;         assign bus1.in_rt = in_rt;
  assign bus0.in_nzp = in_nzp;       assign bus1.in_nzp = in_nzp;
  assign bus0.in_imm = in_imm;       assign bus1.in_imm = in_imm;
  assign bus0.mem_write_ready = mem_ready;
  assign bus1.mem_write_ready = mem_ready;

  instruction_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_BITS(8)) dut0 (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address), .bus(bus0),
    .busy(o_busy[0]), .done(o_done[0]), .err_opcode(o_eop[0]), .err_overflow(o_eov[0])
  );

  instruction_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address[1:0]), .bus(bus1),
    .busy(o_busy[1]), .done(o_done[1]), .err_opcode(o_eop[1]), .err_overflow(o_eov[1])
  );

  assign o_valid[0] = bus0.mem_write_valid;  assign o_valid[1] = bus1.mem_write_valid;
  assign o_ready[0] = bus0.in_ready;         assign o_ready[1] = bus1.in_ready;
  assign o_addr[0]  = bus0.mem_write_address;
  assign o_addr[1]  = {6'b0, bus1.mem_write_address};
  assign o_data[0]  = bus0.mem_write_data;   assign o_data[1]  = bus1.mem_write_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference encoding written as plain field arithmetic
  function automatic int enc(input int op, input int rd, input int rs, input int rt,
                             input int nzp, input int imm);
    case (op)
      3, 4, 5, 6: return op*4096 + rd*256 + rs*16 + rt;
      2, 8:       return op*4096 + rs*16 + rt;
      7:          return op*4096 + rd*256 + rs*16;
      1:          return op*4096 + nzp*512 + imm;
      9:          return op*4096 + rd*256 + imm;
      default:    return op*4096;
    endcase
  endfunction

  // model: 0 idle, 1 active, 2 drain, 3 done
  int m_state[2] = '{0, 0};
  int m_base[2]  = '{0, 0};
  int m_cnt[2]   = '{0, 0};
  int m_eop[2]   = '{0, 0};
  int m_eov[2]   = '{0, 0};
  int q_addr[2][16];
  int q_data[2][16];
  int q_head[2] = '{0, 0};
  int q_tail[2] = '{0, 0};
  int wl_addr[2][64];
  int wl_data[2][64];
  int wl_n[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int qs, rdy, space;
      space = (i == 0) ? 256 : 4;
      qs  = q_tail[i] - q_head[i];
      rdy = (m_state[i] == 1 && qs < DEPTH) ? 1 : 0;
      if (chk_on) begin
        chk($sformatf("valid[%0d]", i), int'(o_valid[i]), (qs != 0) ? 1 : 0);
        if (o_valid[i] && qs != 0) begin
          chk($sformatf("addr[%0d]", i), int'(o_addr[i]), q_addr[i][q_head[i] % 16]);
          chk($sformatf("data[%0d]", i), int'(o_data[i]), q_data[i][q_head[i] % 16]);
        end
        chk($sformatf("in_ready[%0d]", i), int'(o_ready[i]), rdy);
        chk($sformatf("busy[%0d]", i), int'(o_busy[i]), (m_state[i] == 1 || m_state[i] == 2) ? 1 : 0);
        chk($sformatf("done[%0d]", i), int'(o_done[i]), (m_state[i] == 3) ? 1 : 0);
        chk($sformatf("err_opcode[%0d]", i), int'(o_eop[i]), m_eop[i]);
        chk($sformatf("err_overflow[%0d]", i), int'(o_eov[i]), m_eov[i]);
      end
      if (o_valid[i] && mem_ready && !reset && wl_n[i] < 64) begin
        wl_addr[i][wl_n[i]] = int'(o_addr[i]);
        wl_data[i][wl_n[i]] = int'(o_data[i]);
        wl_n[i]++;
      end
      if (reset) begin
        m_state[i] = 0; m_cnt[i] = 0; m_eop[i] = 0; m_eov[i] = 0; m_base[i] = 0;
        q_head[i] = 0; q_tail[i] = 0;
      end else begin
        if (start && (m_state[i] == 0 || m_state[i] == 3)) begin
          m_state[i] = 1; m_base[i] = int'(base_address) % space;
          m_cnt[i] = 0; m_eop[i] = 0; m_eov[i] = 0;
        end else if (m_state[i] == 1 && in_valid && rdy == 1) begin
          if (in_opcode >= 4'hA && in_opcode <= 4'hE) begin
            m_eop[i] = 1;
          end else begin
            if (m_cnt[i] < space) begin
              q_addr[i][q_tail[i] % 16] = (m_base[i] + m_cnt[i]) % space;
              q_data[i][q_tail[i] % 16] = enc(int'(in_opcode), int'(in_rd), int'(in_rs),
                                              int'(in_rt), int'(in_nzp), int'(in_imm));
              q_tail[i]++;
              m_cnt[i]++;
            end else begin
              m_eov[i] = 1;
            end
            if (in_opcode == 4'hF) m_state[i] = 2;
          end
        end else if (m_state[i] == 2 && qs == 0) begin
          m_state[i] = 3;
        end
        if (qs != 0 && mem_ready) q_head[i]++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] base);
    start = 1'b1; base_address = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm);
    int n;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_nzp = nzp; in_imm = imm;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ready[0] && n < 50);
    if (!o_ready[0]) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(o_done[0] && o_done[1]) && n < 100);
    chk("done_wait", int'(o_done[0] && o_done[1]), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_valid[%0d]", tag, i), int'(o_valid[i]), 0);
      chk($sformatf("%s_ready[%0d]", tag, i), int'(o_ready[i]), 0);
      chk($sformatf("%s_busy[%0d]", tag, i), int'(o_busy[i]), 0);
      chk($sformatf("%s_done[%0d]", tag, i), int'(o_done[i]), 0);
      chk($sformatf("%s_errs[%0d]", tag, i), int'({o_eop[i], o_eov[i]}), 0);
      chk($sformatf("%s_addr[%0d]", tag, i), int'(o_addr[i]), 0);
      chk($sformatf("%s_data[%0d]", tag, i), int'(o_data[i]), 0);
    end
  endtask

  task automatic expect_write(input string tag, input int i, input int idx,
                              input int a, input int d);
    chk($sformatf("%s_waddr", tag), wl_addr[i][idx], a);
    chk($sformatf("%s_wdata", tag), wl_data[i][idx], d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    do_reset();
    chk_on = 1'b1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // ADD then RET from 0x10
    mem_ready = 1'b1;
    n0 = wl_n[0];
    pulse_start(8'h10);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    chk("basic_count", wl_n[0] - n0, 2);
    expect_write("basic0", 0, n0, 'h10, 'h3123);
    expect_write("basic1", 0, n0 + 1, 'h11, 'hF000);
    chk("basic_done", int'(o_done[0]), 1);

    // formats with unused fields carrying junk
    n0 = wl_n[0];
    pulse_start(8'h20);
    send(4'h1, 4'hF, 4'h7, 4'h9, 3'b101, 8'h2A);
    send(4'h9, 4'h4, 4'h3, 4'h6, 3'h7, 8'hFF);
    send(4'h8, 4'h7, 4'h2, 4'h5, 3'h7, 8'h55);
    send(4'h7, 4'h3, 4'h4, 4'h9, 3'h7, 8'hAA);
    send(4'h2, 4'h5, 4'h6, 4'h7, 3'h7, 8'hAA);
    send(4'hF, 4'hF, 4'hF, 4'hF, 3'h7, 8'hFF);
    wait_done();
    expect_write("brnzp", 0, n0, 'h20, 'h1A2A);
    expect_write("const", 0, n0 + 1, 'h21, 'h94FF);
    expect_write("str", 0, n0 + 2, 'h22, 'h8025);
    expect_write("ldr", 0, n0 + 3, 'h23, 'h7340);
    expect_write("cmp", 0, n0 + 4, 'h24, 'h2067);
    expect_write("ret", 0, n0 + 5, 'h25, 'hF000);

    // backpressure: four fill the FIFO, the fifth stalls
    mem_ready = 1'b0;
    n0 = wl_n[0];
    pulse_start(8'h40);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'h4, 4'h4, 4'h5, 4'h6, 3'h0, 8'h00);
    send(4'h5, 4'h7, 4'h8, 4'h9, 3'h0, 8'h00);
    send(4'h6, 4'hA, 4'hB, 4'hC, 3'h0, 8'h00);
    in_valid = 1'b1; in_opcode = 4'h9; in_rd = 4'h2; in_imm = 8'h11;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", int'(o_ready[0]), 0);
      chk("stall_addr", int'(o_addr[0]), 'h40);
      chk("stall_data", int'(o_data[0]), 'h3123);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(4'h9, 4'h2, 4'h0, 4'h0, 3'h0, 8'h11);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    chk("bp_count", wl_n[0] - n0, 6);
    expect_write("bp_first", 0, n0, 'h40, 'h3123);
    expect_write("bp_fifth", 0, n0 + 4, 'h44, 'h9211);

    // illegal opcode mid-stream; a start while active is ignored
    n0 = wl_n[0];
    pulse_start(8'h50);
    send(4'h3, 4'h1, 4'h1, 4'h1, 3'h0, 8'h00);
    pulse_start(8'h99);
    send(4'hB, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    send(4'h4, 4'h2, 4'h3, 4'h4, 3'h0, 8'h00);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    chk("illegal_flag", int'(o_eop[0]), 1);
    chk("illegal_count", wl_n[0] - n0, 3);
    expect_write("illegal0", 0, n0, 'h50, 'h3111);
    expect_write("illegal1", 0, n0 + 1, 'h51, 'h4234);
    expect_write("illegal2", 0, n0 + 2, 'h52, 'hF000);

    // address space exhaustion on the 2-bit instance, wrapping from base 2
    n0 = wl_n[0];
    n1 = wl_n[1];
    pulse_start(8'h0E);
    for (int k = 1; k <= 5; k++) send(4'h9, 4'(k), 4'h0, 4'h0, 3'h0, 8'(k * 16));
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    chk("ovf_count1", wl_n[1] - n1, 4);
    expect_write("ovf_w0", 1, n1, 2, 'h9110);
    expect_write("ovf_w1", 1, n1 + 1, 3, 'h9220);
    expect_write("ovf_w2", 1, n1 + 2, 0, 'h9330);
    expect_write("ovf_w3", 1, n1 + 3, 1, 'h9440);
    chk("ovf_flag1", int'(o_eov[1]), 1);
    chk("ovf_flag0", int'(o_eov[0]), 0);
    chk("ovf_count0", wl_n[0] - n0, 6);
    expect_write("ovf_last0", 0, n0 + 5, 'h13, 'hF000);

    // reset during an outstanding write
    mem_ready = 1'b0;
    pulse_start(8'h60);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00);
    @(negedge clk);
    chk("pre_reset_valid", int'(o_valid[0]), 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    mem_ready = 1'b1;
    n0 = wl_n[0];
    pulse_start(8'h70);
    send(4'h9, 4'h5, 4'h0, 4'h0, 3'h0, 8'h5A);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00);
    wait_done();
    chk("post_reset_count", wl_n[0] - n0, 2);
    expect_write("post_reset0", 0, n0, 'h70, 'h955A);
    expect_write("post_reset1", 0, n0 + 1, 'h71, 'hF000);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set encoded-word buffer depth (power of two, >=2).
REQ-002 Parameter ADDR_BITS, default 8, SHALL set program-memory address width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a load session at base_address.
REQ-006 base_address  in  ADDR_BITS  first program-memory address, sampled on start.
REQ-007 in_valid / in_ready  in / out  1 / 1  instruction-field handshake.
REQ-008 in_opcode, in_rd, in_rs, in_rt  in  4 each  opcode and register fields.
REQ-009 in_nzp  in  3  branch condition; in_imm  in  8  immediate.
REQ-010 mem_write_valid / mem_write_ready  out / in  1 / 1  program-memory write handshake.
REQ-011 mem_write_address  out  ADDR_BITS; mem_write_data  out  16.
REQ-012 busy  out  1  high in ACTIVE or DRAIN; done  out  1  high in DONE.
REQ-013 err_opcode  out  1  sticky illegal-opcode flag; err_overflow  out  1  sticky address-space-exhausted flag.

Function
REQ-014 Encoding SHALL place opcode in [15:12], with NOP=0000, BRnzp=0001, CMP=0010, ADD=0011, SUB=0100, MUL=0101, DIV=0110, LDR=0111, STR=1000, CONST=1001, RET=1111.
REQ-015 ADD/SUB/MUL/DIV SHALL encode rd[11:8], rs[7:4], rt[3:0].
REQ-016 CMP SHALL encode 0000 in [11:8], rs[7:4], rt[3:0]; LDR SHALL encode rd[11:8], rs[7:4], 0000 in [3:0]; STR SHALL encode 0000 in [11:8], rs[7:4], rt[3:0].
REQ-017 BRnzp SHALL encode nzp[11:9], 0 in [8], imm[7:0]; CONST SHALL encode rd[11:8], imm[7:0].
REQ-018 NOP and RET SHALL encode zeros in [11:0]; unused input fields SHALL never leak into the word.
REQ-019 FSM states SHALL be IDLE, ACTIVE, DRAIN, DONE.
REQ-020 IDLE: in_ready=0; start -> ACTIVE, write pointer <= base_address, word count <= 0.
REQ-021 ACTIVE: in_ready = !fifo_full; an accepted (in_valid && in_ready) legal instruction SHALL push its encoded word.
REQ-022 An accepted RET SHALL be pushed and SHALL move ACTIVE -> DRAIN; in_ready=0 in DRAIN.
REQ-023 DRAIN -> DONE in the cycle after the final word's write handshake completes, when the FIFO is empty.
REQ-024 DONE: done=1 held; start SHALL begin a new session as in REQ-020; start in ACTIVE or DRAIN SHALL be ignored.
REQ-025 Opcodes 1010-1110 SHALL be accepted, not pushed, and set err_opcode.
REQ-026 mem_write_valid SHALL be high whenever the FIFO is non-empty, presenting the head word and its address; address and data SHALL be held stable until mem_write_ready.
REQ-027 Each write handshake SHALL pop the FIFO and advance the address by 1 modulo 2^ADDR_BITS.
REQ-028 Latency: a word accepted at edge N SHALL appear on mem_write_valid no earlier than the cycle after N and no later than the cycle after the preceding word's handshake.
REQ-029 Accepting a legal instruction when the word count is already 2^ADDR_BITS SHALL drop that instruction and set err_overflow; a RET dropped this way SHALL still move the FSM to DRAIN.
REQ-030 Full FIFO SHALL deassert in_ready; there is no same-cycle bypass.
REQ-031 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-032 Error flags SHALL clear only on reset or on a start that is accepted.

Reset
REQ-033 On reset SHALL go to IDLE and empty the FIFO, with every output at 0, including the errors and the address/data outputs.
REQ-034 Reset during an outstanding write SHALL drop mem_write_valid the next cycle, and the word SHALL be discarded.

Structure
REQ-035 Opcode constants, field bit positions and the FSM state enum SHALL live in shared package gpu_isa_pkg, shared with the decoder.
REQ-036 Buffering SHALL be a sub-module instr_fifo (synchronous, FIFO_DEPTH x 16 bits, full/empty outputs).

Verification
REQ-037 start with base=0x10; feed ADD rd=1 rs=2 rt=3, then RET, with mem_write_ready=1 -> writes 0x3123@0x10 and 0xF000@0x11, then done=1.
REQ-038 BRnzp nzp=101 imm=0x2A with rd=0xF -> data 0x1A2A; CONST rd=4 imm=0xFF -> 0x94FF; STR rd=7 rs=2 rt=5 -> 0x8025.
REQ-039 Hold mem_write_ready=0 and push 5 instructions -> in_ready falls after 4 accepts; address/data stay stable; releasing ready drains in order.
REQ-040 Opcode 1011 mid-stream -> err_opcode=1, no write, following word's address not skipped.
REQ-041 ADDR_BITS=2 with 5 legal instructions -> 4 writes at 0..3 (wrap from base), then err_overflow=1 on the fifth.
REQ-042 Reset asserted while mem_write_valid=1 -> next cycle all outputs 0 and state IDLE; start then works normally.
